compl_acc_dump: RTL and testbench
=================================

COMPL_ACC_DUMP -- requirements
Module: compl_acc_dump

Interface
REQ-001 Parameter DATA_W, default 19: width of signed I/Q input samples, matching the complex multiplier output.
REQ-002 Parameter LEN_W, default 8: width of the frame length input.
REQ-003 Parameter ACC_W, default DATA_W+LEN_W (27): width of signed accumulator and result outputs.
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n_i  in  1  asynchronous, active-low reset.
REQ-006 data_i_i  in  DATA_W  signed in-phase sample.
REQ-007 data_q_i  in  DATA_W  signed quadrature sample.
REQ-008 valid_i  in  1  input sample valid.
REQ-009 ready_o  out  1  block can accept a sample this cycle.
REQ-010 len_i  in  LEN_W  samples per frame; 0 means 2^LEN_W.
REQ-011 clear_i  in  1  synchronous abort of the current frame.
REQ-012 acc_i_o  out  ACC_W  signed in-phase frame sum.
REQ-013 acc_q_o  out  ACC_W  signed quadrature frame sum.
REQ-014 valid_o  out  1  result valid.
REQ-015 ready_i  in  1  downstream accepts the result.

Function
REQ-016 A sample is accepted when valid_i && ready_o; samples are never dropped or duplicated.
REQ-017 Internal state: sample counter cnt (0..len-1), latched length len_q, I/Q accumulators, and an output register with valid flag.
REQ-018 len_i is latched into len_q only when a sample is accepted with cnt==0; len_i changes mid-frame have no effect.
REQ-019 The last sample is the accepted sample with cnt==len-1, using len_i when cnt==0 and len_q otherwise; len of 1 makes every sample the last.
REQ-020 On a non-last accept: accumulators += sign-extended samples; cnt increments.
REQ-021 On the last accept:
  - the output register loads accumulator plus current sample;
  - valid_o is set on the next edge (latency 1 cycle from the last accept);
  - the accumulators and cnt clear to 0 on the same edge.
REQ-022 ACC_W guarantees no overflow for 2^LEN_W full-scale samples; no saturation logic is needed or permitted; addition is exact two's complement.
REQ-023 valid_o stays high with stable acc_*_o until valid_o && ready_i; it then clears on the next edge unless a new last sample loads on that same edge, in which case valid_o stays high with the new result.
REQ-024 ready_o = !clear_i && !(valid_o && !ready_i && next accept would be last); mid-frame samples continue under backpressure.
REQ-025 clear_i high: accumulators and cnt clear to 0, no sample is accepted, and the pending output register and valid_o are unaffected.
REQ-026 valid_i low cycles (gaps) leave all state unchanged.
REQ-027 No combinational path from data inputs to outputs; ready_o depends only on clear_i, ready_i, valid_o, cnt, len_q and len_i.

Reset
REQ-028 rst_n_i low immediately, without a clock edge, sets cnt, len_q, accumulators, acc_i_o and acc_q_o to 0, and valid_o to 0.
REQ-029 ready_o is 1 during and after reset, provided clear_i is low.
REQ-030 Reset deassertion takes effect at the first clk_i edge after rst_n_i goes high; a frame interrupted by reset is discarded.

Verification
REQ-031 len_i=4, ready_i=1, I=1,2,3,4, Q=-1 each -> one cycle after the 4th accept: valid_o=1 for one cycle, acc_i_o=10, acc_q_o=-4.
REQ-032 len_i=0, 256 samples I=262143, Q=-262144 -> acc_i_o=67108608, acc_q_o=-67108864, with no wrap.
REQ-033 len_i=1, ready_i=0, two samples offered:
  - the first is accepted and valid_o=1;
  - ready_o=0 and the second waits with the result held stable;
  - ready_i raised -> ready_o=1 the same cycle, the second is accepted, and valid_o stays 1 with the new result.
REQ-034 len_i=4, two samples of 7, clear_i pulse, then four samples of 5 -> a single result of acc_i_o=20.
REQ-035 len_i=3 with valid_i gaps of 0-3 cycles between samples 1,1,1 -> acc_i_o=3 one cycle after the 3rd accept.
REQ-036 rst_n_i low mid-frame and while valid_o=1 -> valid_o=0 and all outputs 0 before the next edge; the next frame sums only post-reset samples.

Source files
------------

// File: rtl/compl_acc_dump.sv
// Complex (I/Q) frame accumulator with a one-deep result register and
// valid/ready handshakes on both sides.
module compl_acc_dump #(
  parameter int DATA_W = 19,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = DATA_W + LEN_W
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic signed [DATA_W-1:0] data_i_i,
  input  logic signed [DATA_W-1:0] data_q_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [LEN_W-1:0]         len_i,
  input  logic                     clear_i,
  output logic signed [ACC_W-1:0]  acc_i_o,
  output logic signed [ACC_W-1:0]  acc_q_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        len_sel;
  logic [LEN_W:0]          len_full;
  logic                    is_last;
  logic                    accept;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] ext_i;
  logic signed [ACC_W-1:0] ext_q;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;

  // The first sample of a frame uses the live length; later ones the latched copy.
  assign len_sel  = (cnt == '0) ? len_i : len_q;
  assign len_full = (len_sel == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len_sel};
  assign is_last  = ({1'b0, cnt} == (len_full - (LEN_W+1)'(1)));

  // Only a frame-closing sample needs a free output slot.
  assign ready_o = !clear_i && !(valid_o && !ready_i && is_last);
  assign accept  = valid_i && ready_o;

  assign ext_i = {{(ACC_W-DATA_W){data_i_i[DATA_W-1]}}, data_i_i};
  assign ext_q = {{(ACC_W-DATA_W){data_q_i[DATA_W-1]}}, data_q_i};
  assign sum_i = acc_i + ext_i;
  assign sum_q = acc_q + ext_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt     <= '0;
      len_q   <= '0;
      acc_i   <= '0;
      acc_q   <= '0;
      acc_i_o <= '0;
      acc_q_o <= '0;
      valid_o <= 1'b0;
    end else begin
      if (clear_i) begin
        cnt   <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end else if (accept) begin
        if (cnt == '0)
          len_q <= len_i;
        if (is_last) begin
          cnt   <= '0;
          acc_i <= '0;
          acc_q <= '0;
        end else begin
          cnt   <= cnt + LEN_W'(1);
          acc_i <= sum_i;
          acc_q <= sum_q;
        end
      end

      // A new result may load on the same edge the old one is taken.
      if (accept && is_last) begin
        acc_i_o <= sum_i;
        acc_q_o <= sum_q;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_compl_acc_dump.sv
// Scoreboard bench for compl_acc_dump: frame-level reference model feeds an
// expected-result queue that a separate monitor drains on output handshakes.
module tb_compl_acc_dump;

  localparam int DW = 19;
  localparam int LW = 8;
  localparam int AW = DW + LW;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic signed [DW-1:0] data_i_i = '0;
  logic signed [DW-1:0] data_q_i = '0;
  logic                 valid_i = 1'b0;
  logic                 ready_o;
  logic [LW-1:0]        len_i = '0;
  logic                 clear_i = 1'b0;
  logic signed [AW-1:0] acc_i_o;
  logic signed [AW-1:0] acc_q_o;
  logic                 valid_o;
  logic                 ready_i = 1'b0;

  compl_acc_dump #(.DATA_W(DW), .LEN_W(LW), .ACC_W(AW)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .data_i_i(data_i_i),
    .data_q_i(data_q_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .len_i   (len_i),
    .clear_i (clear_i),
    .acc_i_o (acc_i_o),
    .acc_q_o (acc_q_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model state, expressed in frames rather than counters.
  longint exp_i_q[$];
  longint exp_q_q[$];
  int     m_n = 0;
  int     m_len = 1;
  longint m_sum_i = 0;
  longint m_sum_q = 0;
  bit     m_pend = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check ready, advance the model.
  task automatic cycle(input bit v, input longint di, input longint dq,
                       input int ln, input bit clr, input bit rdy);
    int     cur_len;
    bit     exp_rdy;
    bit     load;
    @(negedge clk_i);
    valid_i  = v;
    data_i_i = DW'(di);
    data_q_i = DW'(dq);
    len_i    = LW'(ln);
    clear_i  = clr;
    ready_i  = rdy;
    cur_len  = (m_n == 0) ? ((ln == 0) ? 256 : ln) : m_len;
    exp_rdy  = !clr && !(m_pend && !rdy && (m_n + 1 == cur_len));
    #1;
    check("ready_o", longint'(ready_o), longint'(exp_rdy));
    load = 0;
    if (clr) begin
      m_n = 0; m_sum_i = 0; m_sum_q = 0;
    end else if (v && exp_rdy) begin
      if (m_n == 0) m_len = cur_len;
      m_sum_i += longint'(data_i_i);
      m_sum_q += longint'(data_q_i);
      m_n++;
      if (m_n == m_len) begin
        exp_i_q.push_back(m_sum_i);
        exp_q_q.push_back(m_sum_q);
        m_n = 0; m_sum_i = 0; m_sum_q = 0;
        load = 1;
      end
    end
    if (load) m_pend = 1;
    else if (m_pend && rdy) m_pend = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 1, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    valid_i = 0; ready_i = 0; clear_i = 0;
    #3 rst_n_i = 1'b0;
    #1;
    check("rst valid_o", longint'(valid_o), 0);
    check("rst acc_i_o", longint'(acc_i_o), 0);
    check("rst acc_q_o", longint'(acc_q_o), 0);
    check("rst ready_o", longint'(ready_o), 1);
    exp_i_q.delete(); exp_q_q.delete();
    m_n = 0; m_sum_i = 0; m_sum_q = 0; m_pend = 0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Monitor: a result leaves the DUT when valid_o && ready_i at the next edge.
  initial begin
    longint ei, eq;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_n_i && valid_o && ready_i) begin
        if (exp_i_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected result: got i=%0d q=%0d expected none",
                   acc_i_o, acc_q_o);
        end else begin
          ei = exp_i_q.pop_front();
          eq = exp_q_q.pop_front();
          check("acc_i_o", longint'(acc_i_o), ei);
          check("acc_q_o", longint'(acc_q_o), eq);
        end
      end
    end
  end

  initial begin
    int ln;
    #2;
    check("reset valid_o", longint'(valid_o), 0);
    check("reset acc_i_o", longint'(acc_i_o), 0);
    check("reset ready_o", longint'(ready_o), 1);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Basic frame of four.
    for (int k = 1; k <= 4; k++) cycle(1, k, -1, 4, 0, 1);
    idle(3);

    // Full-scale frame with len 0 -> 256 samples.
    for (int k = 0; k < 256; k++) cycle(1, 262143, -262144, 0, 0, 1);
    idle(3);

    // Output backpressure with len 1.
    cycle(1, 11, -3, 1, 0, 0);
    cycle(1, 22, 5, 1, 0, 0);
    cycle(1, 22, 5, 1, 0, 0);
    cycle(1, 22, 5, 1, 0, 1);
    idle(3);

    // Clear aborts a partial frame.
    cycle(1, 7, 7, 4, 0, 1);
    cycle(1, 7, 7, 4, 0, 1);
    cycle(0, 0, 0, 4, 1, 1);
    for (int k = 0; k < 4; k++) cycle(1, 5, 0, 4, 0, 1);
    idle(3);

    // Gaps of 0..3 cycles, len changing mid-frame must be ignored.
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 2, (k == 0) ? 3 : 7, 0, 1);
      for (int g = 0; g < k + 1 && k < 2; g++) cycle(0, 0, 0, 9, 0, 1);
    end
    idle(3);

    // Randomized traffic.
    for (int k = 0; k < 4000; k++) begin
      ln = ($urandom_range(0, 199) == 0) ? 0 : int'($urandom_range(1, 6));
      cycle($urandom_range(0, 9) < 7,
            longint'($signed(DW'($urandom))), longint'($signed(DW'($urandom))),
            ln, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
    end
    idle(4);

    // Reset with a result pending and a frame in progress.
    cycle(1, 100, 100, 1, 0, 0);
    cycle(1, 3, 3, 4, 0, 0);
    cycle(1, 3, 3, 4, 0, 0);
    do_reset();
    cycle(1, 9, -9, 2, 0, 1);
    cycle(1, 4, -4, 2, 0, 1);
    idle(4);

    check("results outstanding", longint'(exp_i_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
